// File: rtl/multicore_memory_arbiter.sv
// rtl/multicore_memory_arbiter.sv - shares one memory port among NUM_CORES cores, one whole transaction per grant
// Defining MULTICORE_MEMARB_FIXED_PRIORITY_EN replaces round-robin with lowest-index-wins arbitration.
module multicore_memory_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 21,
   parameter int NUM_CORES     = 4,
   parameter int IDX_W         = $clog2(NUM_CORES)
) (
   input  logic                               i_Clk,
   input  logic                               i_Reset_n,
   input  logic [NUM_CORES-1:0]               i_Core_MEM_Valid,
   input  logic [NUM_CORES*ADDRESS_WIDTH-1:0] i_Core_MEM_Address,
   input  logic [NUM_CORES-1:0]               i_Core_MEM_Read_Write_n,
   input  logic [NUM_CORES*DATA_WIDTH-1:0]    i_Core_MEM_Data,
   output logic [NUM_CORES-1:0]               o_Core_MEM_Valid,
   output logic [NUM_CORES-1:0]               o_Core_MEM_Data_Read,
   output logic [NUM_CORES-1:0]               o_Core_MEM_Last,
   output logic [DATA_WIDTH-1:0]              o_Core_MEM_Data,
   output logic                               o_MEM_Valid,
   output logic [ADDRESS_WIDTH-1:0]           o_MEM_Address,
   output logic                               o_MEM_Read_Write_n,
   output logic [DATA_WIDTH-1:0]              o_MEM_Data,
   input  logic                               i_MEM_Data_Read,
   input  logic [DATA_WIDTH-1:0]              i_MEM_Data,
   input  logic                               i_MEM_Valid,
   input  logic                               i_MEM_Last,
   output logic [NUM_CORES-1:0]               o_Grant
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] next_idx;
   logic             busy;

   assign busy = (state == BUSY);

`ifdef MULTICORE_MEMARB_FIXED_PRIORITY_EN
   always_comb begin
      next_idx = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (i_Core_MEM_Valid[k]) next_idx = IDX_W'(k);
      end
   end
`else
   logic [IDX_W-1:0] last_idx;
   int               rank;
   int               best_rank;

   // Rank each core by its distance past the previous owner; the nearest requester wins.
   always_comb begin
      next_idx  = '0;
      best_rank = NUM_CORES;
      rank      = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         rank = k - int'(last_idx) - 1;
         if (rank < 0) rank = rank + NUM_CORES;
         if (i_Core_MEM_Valid[k] && (rank < best_rank)) begin
            best_rank = rank;
            next_idx  = IDX_W'(k);
         end
      end
   end
`endif

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state     <= IDLE;
         grant_idx <= '0;
`ifndef MULTICORE_MEMARB_FIXED_PRIORITY_EN
         last_idx  <= IDX_W'(NUM_CORES - 1);
`endif
      end else if (state == IDLE) begin
         if (|i_Core_MEM_Valid) begin
            grant_idx <= next_idx;
            state     <= BUSY;
         end
      end else if (i_MEM_Last) begin
`ifndef MULTICORE_MEMARB_FIXED_PRIORITY_EN
         last_idx <= grant_idx;
`endif
         state    <= IDLE;
      end
   end

   // The memory owns the transaction once granted, so the owner's Valid is not consulted while BUSY.
   always_comb begin
      o_MEM_Valid          = busy;
      o_MEM_Address        = '0;
      o_MEM_Read_Write_n   = 1'b1;
      o_MEM_Data           = '0;
      o_Core_MEM_Valid     = '0;
      o_Core_MEM_Data_Read = '0;
      o_Core_MEM_Last      = '0;
      o_Grant              = '0;
      o_Core_MEM_Data      = busy ? i_MEM_Data : '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (busy && (grant_idx == IDX_W'(k))) begin
            o_MEM_Address           = i_Core_MEM_Address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            o_MEM_Read_Write_n      = i_Core_MEM_Read_Write_n[k];
            o_MEM_Data              = i_Core_MEM_Data[k*DATA_WIDTH +: DATA_WIDTH];
            o_Core_MEM_Valid[k]     = i_MEM_Valid;
            o_Core_MEM_Data_Read[k] = i_MEM_Data_Read;
            o_Core_MEM_Last[k]      = i_MEM_Last;
            o_Grant[k]              = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicore_memory_arbiter.sv
// tb/tb_multicore_memory_arbiter.sv - table, directed and randomized checks of multicore_memory_arbiter
module tb_multicore_memory_arbiter;
   localparam int DW = 32;
   localparam int AW = 21;
   localparam int NC = 4;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic [NC-1:0]    core_valid = '0;
   logic [NC*AW-1:0] core_addr  = '0;
   logic [NC-1:0]    core_rw    = '1;
   logic [NC*DW-1:0] core_data  = '0;
   logic             mem_dread  = 1'b0;
   logic             mem_valid  = 1'b0;
   logic             mem_last   = 1'b0;
   logic [DW-1:0]    mem_data   = '0;
   logic [NC-1:0]    o_core_valid, o_core_dread, o_core_last, o_grant;
   logic [DW-1:0]    o_core_data, o_mem_data;
   logic             o_mem_valid, o_mem_rw;
   logic [AW-1:0]    o_mem_addr;

   multicore_memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CORES(NC)) dut (
      .i_Clk                   (clk),
      .i_Reset_n               (rst_n),
      .i_Core_MEM_Valid        (core_valid),
      .i_Core_MEM_Address      (core_addr),
      .i_Core_MEM_Read_Write_n (core_rw),
      .i_Core_MEM_Data         (core_data),
      .o_Core_MEM_Valid        (o_core_valid),
      .o_Core_MEM_Data_Read    (o_core_dread),
      .o_Core_MEM_Last         (o_core_last),
      .o_Core_MEM_Data         (o_core_data),
      .o_MEM_Valid             (o_mem_valid),
      .o_MEM_Address           (o_mem_addr),
      .o_MEM_Read_Write_n      (o_mem_rw),
      .o_MEM_Data              (o_mem_data),
      .i_MEM_Data_Read         (mem_dread),
      .i_MEM_Data              (mem_data),
      .i_MEM_Valid             (mem_valid),
      .i_MEM_Last              (mem_last),
      .o_Grant                 (o_grant)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NC-1:0] valid;
      logic          mval;
      logic          mlast;
      logic [NC-1:0] e_grant;
      logic          e_mvalid;
      logic [NC-1:0] e_cvalid;
      logic [NC-1:0] e_clast;
   } vec_t;

   vec_t tbl [14];
   int   passed = 0;
   int   total  = 0;
   bit   m_busy;
   int   m_owner, m_last, just_done, max_wait;
   int   waits [NC];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic logic [127:0] mem_side();
      return 128'({o_mem_valid, o_mem_rw, o_mem_addr, o_mem_data});
   endfunction

   function automatic logic [127:0] core_side();
      return 128'({o_grant, o_core_valid, o_core_dread, o_core_last, o_core_data});
   endfunction

   task automatic model_reset();
      m_busy    = 1'b0;
      m_owner   = 0;
      m_last    = NC - 1;
      just_done = -1;
   endtask

   function automatic int pick();
`ifdef MULTICORE_MEMARB_FIXED_PRIORITY_EN
      for (int s = 0; s < NC; s++) if (core_valid[s]) return s;
`else
      for (int s = 1; s <= NC; s++) if (core_valid[(m_last + s) % NC]) return (m_last + s) % NC;
`endif
      return 0;
   endfunction

   task automatic model_check();
      logic [NC-1:0] oh;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          erw;
      oh = '0; ea = '0; ed = '0; erw = 1'b1;
      if (m_busy) begin
         oh  = NC'(1) << m_owner;
         ea  = core_addr[m_owner*AW +: AW];
         ed  = core_data[m_owner*DW +: DW];
         erw = core_rw[m_owner];
      end
      check("model_mem_side", mem_side(), 128'({m_busy, erw, ea, ed}));
      check("model_core_side", core_side(),
            128'({oh, mem_valid ? oh : '0, mem_dread ? oh : '0, mem_last ? oh : '0,
                  m_busy ? mem_data : '0}));
   endtask

   task automatic model_advance();
      just_done = -1;
      if (!m_busy) begin
         if (|core_valid) begin
            m_owner = pick();
            m_busy  = 1'b1;
            for (int k = 0; k < NC; k++) begin
               if (k != m_owner && core_valid[k]) begin
                  waits[k]++;
                  if (waits[k] > max_wait) max_wait = waits[k];
               end else begin
                  waits[k] = 0;
               end
            end
         end
      end else if (mem_last) begin
         m_last    = m_owner;
         m_busy    = 1'b0;
         just_done = m_owner;
      end
   endtask

   task automatic eval_cycle();
      #1;
      model_check();
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic set_core(input int k, input logic v, input logic rw,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      core_valid[k]         = v;
      core_rw[k]            = rw;
      core_addr[k*AW +: AW] = a;
      core_data[k*DW +: DW] = d;
   endtask

   initial begin
      logic [NC-1:0] exp_g, req;
      int            beat;

      tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000};
      tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001};
      tbl[3]  = '{4'b1110, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
      tbl[4]  = '{4'b1110, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000};
      tbl[5]  = '{4'b1110, 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0010, 4'b0010};
      tbl[6]  = '{4'b1100, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b1100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000};
      tbl[8]  = '{4'b1100, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0100};
      tbl[9]  = '{4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
      tbl[10] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000};
      tbl[11] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000, 4'b1000};
      tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
      tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000};

      model_reset();
      max_wait = 0;
      for (int k = 0; k < NC; k++) begin
         waits[k] = 0;
         set_core(k, 1'b0, 1'b1, AW'(32'h1000 * (k + 1)), 32'hD000_0000 + k);
      end

      #2;
      check("reset_mem_side", mem_side(), 128'({1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}}));
      check("reset_core_side", core_side(), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All four cores at once, 2-beat bursts, each drops after its Last.
      for (int r = 0; r < 14; r++) begin
         core_valid = tbl[r].valid;
         mem_valid  = tbl[r].mval;
         mem_last   = tbl[r].mlast;
         eval_cycle();
         check($sformatf("vec%0d", r), 128'({o_grant, o_mem_valid, o_core_valid, o_core_last}),
               128'({tbl[r].e_grant, tbl[r].e_mvalid, tbl[r].e_cvalid, tbl[r].e_clast}));
         clock_edge();
      end

      // Core 2 read, 4 beats; core 3 joins on the Last beat while core 2 keeps requesting.
      mem_valid = 1'b0;
      mem_last  = 1'b0;
      core_valid = '0;
      set_core(2, 1'b1, 1'b1, 21'h00100, 32'h0);
      eval_cycle();
      check("c2_req_cycle_idle", 128'(o_mem_valid), 128'(0));
      clock_edge();
      for (int b = 0; b < 4; b++) begin
         mem_valid = 1'b1;
         mem_data  = $urandom;
         mem_last  = (b == 3);
         if (b == 3) core_valid[3] = 1'b1;
         eval_cycle();
         check("c2_addr", 128'(o_mem_addr), 128'(21'h00100));
         check("c2_beat_valid", 128'(o_core_valid), 128'(4'b0100));
         check("c2_beat_last", 128'(o_core_last), 128'((b == 3) ? 4'b0100 : 4'b0000));
         clock_edge();
      end
      mem_valid = 1'b0;
      mem_last  = 1'b0;
      eval_cycle();
      check("c2_gap_idle", 128'({o_mem_valid, o_grant}), 128'(0));
      clock_edge();
      mem_last = 1'b1;
      eval_cycle();
`ifdef MULTICORE_MEMARB_FIXED_PRIORITY_EN
      exp_g = 4'b0100;
`else
      exp_g = 4'b1000;
`endif
      check("c2_rearb_grant", 128'(o_grant), 128'(exp_g));
      clock_edge();
      mem_last   = 1'b0;
      core_valid = '0;
      eval_cycle();
      clock_edge();

      // Core 3 write, Data_Read pulsed every other cycle; core 3 drops Valid mid-burst.
      set_core(3, 1'b1, 1'b0, 21'h1F0F0, 32'hA0);
      eval_cycle();
      clock_edge();
      beat = 0;
      for (int c = 0; c < 7; c++) begin
         mem_dread = (c % 2 == 0);
         mem_last  = (c == 6);
         core_data[3*DW +: DW] = 32'hA0 + beat;
         if (c == 3) core_valid[3] = 1'b0;
         eval_cycle();
         check("c3_rw", 128'(o_mem_rw), 128'(0));
         check("c3_wdata", 128'(o_mem_data), 128'(32'hA0 + beat));
         check("c3_dread", 128'(o_core_dread), 128'(mem_dread ? 4'b1000 : 4'b0000));
         if (c >= 3) check("c3_hold_after_drop", 128'(o_mem_valid), 128'(1));
         clock_edge();
         if (mem_dread) beat++;
      end
      mem_dread  = 1'b0;
      mem_last   = 1'b0;
      core_valid = '0;
      core_rw    = '1;
      eval_cycle();
      check("c3_done_idle", 128'(o_mem_valid), 128'(0));
      clock_edge();

      // Reset in the middle of a core 1 read; core 0 must win after release.
      set_core(1, 1'b1, 1'b1, 21'h00ABC, 32'h0);
      eval_cycle();
      clock_edge();
      mem_valid = 1'b1;
      mem_data  = 32'h1234_5678;
      eval_cycle();
      check("c1_beat1", 128'(o_core_valid), 128'(4'b0010));
      clock_edge();
      core_valid[0] = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_side", mem_side(), 128'({1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}}));
      check("rst_mid_core_side", core_side(), 128'(0));
      model_reset();
      rst_n = 1'b1;
      #1;
      model_check();
      mem_valid = 1'b0;
      clock_edge();
      mem_last = 1'b1;
      eval_cycle();
      check("rst_first_grant", 128'(o_grant), 128'(4'b0001));
      clock_edge();
      mem_last   = 1'b0;
      core_valid = '0;
      eval_cycle();
      clock_edge();

      // Two cores requesting continuously.
`ifdef MULTICORE_MEMARB_FIXED_PRIORITY_EN
      req = 4'b0101;
`else
      req = 4'b0011;
`endif
      core_valid = req;
      for (int t = 0; t < 6; t++) begin
         eval_cycle();
         clock_edge();
         mem_last = 1'b1;
         eval_cycle();
`ifdef MULTICORE_MEMARB_FIXED_PRIORITY_EN
         exp_g = 4'b0001;
`else
         exp_g = (t % 2 == 0) ? 4'b0010 : 4'b0001;
`endif
         check($sformatf("alt_grant%0d", t), 128'(o_grant), 128'(exp_g));
         clock_edge();
         mem_last = 1'b0;
      end
      core_valid = '0;
      eval_cycle();
      clock_edge();

      // Randomized traffic against the reference model.
      for (int k = 0; k < NC; k++) waits[k] = 0;
      max_wait = 0;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < NC; k++) begin
            if (!core_valid[k]) begin
               if ($urandom_range(2) == 0)
                  set_core(k, 1'b1, 1'($urandom_range(1)), AW'($urandom), $urandom);
            end else if (k == just_done) begin
               if ($urandom_range(1) == 0) begin
                  core_valid[k] = 1'b0;
                  waits[k]      = 0;
               end else begin
                  set_core(k, 1'b1, 1'($urandom_range(1)), AW'($urandom), $urandom);
               end
            end
            core_data[k*DW +: DW] = $urandom;
         end
         mem_valid = 1'($urandom_range(1));
         mem_dread = 1'($urandom_range(1));
         mem_last  = ($urandom_range(3) == 0);
         mem_data  = $urandom;
         eval_cycle();
         clock_edge();
      end
`ifndef MULTICORE_MEMARB_FIXED_PRIORITY_EN
      check("rr_fairness_bound", 128'(max_wait <= NC - 1), 128'(1));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicore_memory_arbiter.md
Name: multicore_memory_arbiter

Overview:
- Shares one external memory port between NUM_CORES per-core memory interfaces. Each core interface is the output of that core's I/D arbiter.
- Grants are round-robin, one full transaction at a time. The grant is held from the first request cycle until memory signals the last beat.
- Sits between the core array and the memory controller. Addresses are word addresses; bursts end on i_MEM_Last.

Parameters:
DATA_WIDTH, 32, data bus width per beat
ADDRESS_WIDTH, 21, word address width
NUM_CORES, 4, number of requesting cores (2..8); IDX_W = $clog2(NUM_CORES)

Ports:
i_Clk  input  1  clock
i_Reset_n  input  1  asynchronous active-low reset
i_Core_MEM_Valid  input  NUM_CORES  per-core request valid
i_Core_MEM_Address  input  NUM_CORES*ADDRESS_WIDTH  per-core address, core k at [k*AW +: AW]
i_Core_MEM_Read_Write_n  input  NUM_CORES  1=read, 0=write
i_Core_MEM_Data  input  NUM_CORES*DATA_WIDTH  per-core write data
o_Core_MEM_Valid  output  NUM_CORES  read beat valid, granted core only
o_Core_MEM_Data_Read  output  NUM_CORES  write beat consumed, granted core only
o_Core_MEM_Last  output  NUM_CORES  last beat, granted core only
o_Core_MEM_Data  output  DATA_WIDTH  read data broadcast to all cores
o_MEM_Valid  output  1  request valid to memory
o_MEM_Address  output  ADDRESS_WIDTH  request address
o_MEM_Read_Write_n  output  1  request direction
o_MEM_Data  output  DATA_WIDTH  write data
i_MEM_Data_Read  input  1  memory consumed current write beat
i_MEM_Data  input  DATA_WIDTH  read data
i_MEM_Valid  input  1  read beat valid
i_MEM_Last  input  1  last beat of transaction
o_Grant  output  NUM_CORES  one-hot current owner (status)

Behaviour:
- Reset: i_Reset_n low, asynchronous. State=IDLE, Grant_Idx=0, Last_Idx=NUM_CORES-1, so core 0 wins first.
- Reset output values: all outputs 0; o_MEM_Read_Write_n=1.
- State IDLE:
  - If any i_Core_MEM_Valid, register Grant_Idx = first requesting core scanning from Last_Idx+1 with wrap-around, and go to BUSY.
  - Else stay in IDLE.
  - Memory-side outputs are 0 (o_MEM_Read_Write_n=1).
  - Arbitration latency: exactly 1 cycle from request to o_MEM_Valid.
- State BUSY, combinational mux of core Grant_Idx:
  - o_MEM_Valid=1.
  - Address, Read_Write_n and Data come from core Grant_Idx.
  - i_MEM_Valid, i_MEM_Data_Read and i_MEM_Last are routed only to bit Grant_Idx of the per-core outputs; other bits are 0.
  - o_Core_MEM_Data = i_MEM_Data whenever BUSY, else 0.
- BUSY to IDLE: on a cycle with i_MEM_Last=1. At that edge Last_Idx <= Grant_Idx.
- Back-to-back transactions: always separated by exactly one IDLE cycle.
- Grant during IDLE: Grant_Idx is not updated until a request appears, so o_Grant shows the last owner only while BUSY. o_Grant is 0 in IDLE.
- Mid-transaction drop: the granted core dropping i_Core_MEM_Valid before Last does not release the grant. BUSY continues until i_MEM_Last; the memory owns the transaction.
- Requests from non-granted cores are ignored while BUSY. They must hold Valid until they see their own Last.
- Simultaneous i_MEM_Last and a new request from the same core: Last completes the current transaction. The new request is arbitrated in the following IDLE cycle with that core at lowest priority.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No completion is signalled to the core.
- Fairness bound: any continuously requesting core is granted within NUM_CORES-1 other transactions.

Optional Feature:
- Macro MULTICORE_MEMARB_FIXED_PRIORITY_EN.
- Defined: IDLE picks the lowest-index requesting core. Last_Idx is neither updated nor used. Core 0 has highest priority, and starvation is permitted.
- Undefined: round-robin as above.
- The two modes are otherwise cycle-identical.

Test Plan:
- Core 2 only, read at address 0x00100, memory returns 4 beats with Last on beat 4 -> o_MEM_Valid rises 1 cycle after request, o_MEM_Address=0x00100, o_Core_MEM_Valid=4'b0100 on each beat, o_Core_MEM_Last=4'b0100 on beat 4, then one IDLE cycle.
- All 4 cores request at once from reset, each with a 2-beat burst -> grant order 0,1,2,3. o_Grant sequence 0001,0010,0100,1000, each BUSY period followed by one IDLE cycle.
- Cores 0 and 1 request continuously -> grants alternate 0,1,0,1. Core 0 is never granted twice in a row.
- Core 3 write of 4 beats with data 0xA0..0xA3, i_MEM_Data_Read pulsed 4 times -> o_MEM_Read_Write_n=0, o_MEM_Data follows core 3 data, o_Core_MEM_Data_Read=4'b1000 on each pulse and other bits 0.
- Core 1 BUSY, reset asserted on beat 2 -> all outputs 0 the same cycle. After release, core 0 (if requesting) is granted first.
- Macro defined, cores 0 and 2 request continuously -> core 0 granted every transaction and core 2 never granted.
